// File: rtl/mult_seq.sv
// mult_seq: sequential 32x32 shift-and-add multiplier that borrows the
// shared ALU adder for one accumulation per granted cycle.
// Ports:
//   clock, ctrl_reset             - clock, synchronous active-high reset
//   ctrl_MULT                     - start request
//   data_operandA/B               - multiplicand / multiplier, taken on start
//   data_result, data_resultRDY   - low 32 product bits, one-cycle ready pulse
//   busy                          - high while running or presenting a result
//   alu_req, alu_grant            - ALU request / ownership for this cycle
//   alu_opcode, alu_operandA/B,
//   alu_shiftamt                  - operation and operands sent to the ALU
//   alu_result                    - combinational ALU sum
module mult_seq (
   input  logic        clock,
   input  logic        ctrl_reset,
   input  logic        ctrl_MULT,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] data_result,
   output logic        data_resultRDY,
   output logic        busy,
   output logic        alu_req,
   input  logic        alu_grant,
   output logic [4:0]  alu_opcode,
   output logic [31:0] alu_operandA,
   output logic [31:0] alu_operandB,
   output logic [4:0]  alu_shiftamt,
   input  logic [31:0] alu_result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [31:0] acc;
   logic [4:0]  count;
   logic        last;

   // Finish once no set multiplier bits remain above the one being
   // consumed now, or when the 32nd iteration is under way.
   assign last = (mplier[31:1] == 31'd0) || (count == 5'd31);

   // alu_req is high exactly in RUN, so it gates the operands.
   assign alu_opcode   = 5'b00000;
   assign alu_shiftamt = 5'd0;
   assign alu_operandA = alu_req ? acc : 32'd0;
   assign alu_operandB = (alu_req && mplier[0]) ? mcand : 32'd0;

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         state          <= IDLE;
         mcand          <= 32'd0;
         mplier         <= 32'd0;
         acc            <= 32'd0;
         count          <= 5'd0;
         data_result    <= 32'd0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
         alu_req        <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ctrl_MULT) begin
                  mcand   <= data_operandA;
                  mplier  <= data_operandB;
                  acc     <= 32'd0;
                  count   <= 5'd0;
                  state   <= RUN;
                  busy    <= 1'b1;
                  alu_req <= 1'b1;
               end
            end
            RUN: begin
               // Without the grant nothing moves; operands stay presented.
               if (alu_grant) begin
                  acc    <= alu_result;
                  mcand  <= {mcand[30:0], 1'b0};
                  mplier <= {1'b0, mplier[31:1]};
                  count  <= count + 5'd1;
                  if (last) begin
                     state          <= DONE;
                     data_result    <= alu_result;
                     data_resultRDY <= 1'b1;
                     alu_req        <= 1'b0;
                  end
               end
            end
            DONE: begin
               // A new start here chains directly into the next operation.
               if (ctrl_MULT) begin
                  mcand   <= data_operandA;
                  mplier  <= data_operandB;
                  acc     <= 32'd0;
                  count   <= 5'd0;
                  state   <= RUN;
                  busy    <= 1'b1;
                  alu_req <= 1'b1;
               end else begin
                  state   <= IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               alu_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed-vector bench for mult_seq with a behavioural ALU.
// Cycle c is the interval after clock edge c-1 (start taken at edge 0).
module tb_mult_seq;

   logic        clock = 1'b0;
   logic        ctrl_reset;
   logic        ctrl_MULT;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_resultRDY;
   logic        busy;
   logic        alu_req;
   logic        alu_grant;
   logic [4:0]  alu_opcode;
   logic [31:0] alu_operandA;
   logic [31:0] alu_operandB;
   logic [4:0]  alu_shiftamt;
   logic [31:0] alu_result;

   int checks = 0;
   int errors = 0;

   // stimulus per cycle
   logic [63:0] mult_m, rst_m, stall_m;
   logic [31:0] opa_in [64];
   logic [31:0] opb_in [64];

   // observations per cycle
   logic [63:0] rdy_m, busy_m, req_m;
   logic [31:0] res_m [64];
   logic [31:0] aa_m [64];
   logic [31:0] ab_m [64];

   always #5 clock = ~clock;

   // ALU is only a real adder while granted; otherwise junk.
   assign alu_result = alu_grant ? (alu_operandA + alu_operandB)
                                 : 32'hDEADBEEF;

   mult_seq dut (
      .clock          (clock),
      .ctrl_reset     (ctrl_reset),
      .ctrl_MULT      (ctrl_MULT),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_resultRDY (data_resultRDY),
      .busy           (busy),
      .alu_req        (alu_req),
      .alu_grant      (alu_grant),
      .alu_opcode     (alu_opcode),
      .alu_operandA   (alu_operandA),
      .alu_operandB   (alu_operandB),
      .alu_shiftamt   (alu_shiftamt),
      .alu_result     (alu_result)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic clear_stim();
      mult_m  = '0;
      rst_m   = '0;
      stall_m = '0;
      for (int i = 0; i < 64; i++) begin
         opa_in[i] = 32'd0;
         opb_in[i] = 32'd0;
      end
   endtask

   // Called at edge+1; start is taken on the next edge (edge 0).
   task automatic start(input logic [31:0] a, input logic [31:0] b);
      ctrl_MULT     = 1'b1;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
   endtask

   // Run cycles 1..maxc applying stimulus tables, sampling mid-cycle.
   task automatic watch(input int maxc);
      rdy_m  = '0;
      busy_m = '0;
      req_m  = '0;
      for (int c = 0; c < 64; c++) begin
         res_m[c] = 32'hX;
         aa_m[c]  = 32'hX;
         ab_m[c]  = 32'hX;
      end
      for (int c = 1; c <= maxc; c++) begin
         ctrl_MULT     = mult_m[c];
         ctrl_reset    = rst_m[c];
         alu_grant     = !stall_m[c];
         data_operandA = opa_in[c];
         data_operandB = opb_in[c];
         #3;
         rdy_m[c]  = data_resultRDY;
         busy_m[c] = busy;
         req_m[c]  = alu_req;
         res_m[c]  = data_result;
         aa_m[c]   = alu_operandA;
         ab_m[c]   = alu_operandB;
         @(posedge clock);
         #1;
      end
      ctrl_MULT  = 1'b0;
      ctrl_reset = 1'b0;
      alu_grant  = 1'b1;
   endtask

   initial begin
      ctrl_reset    = 1'b1;
      ctrl_MULT     = 1'b0;
      data_operandA = 32'd0;
      data_operandB = 32'd0;
      alu_grant     = 1'b1;
      clear_stim();
      repeat (2) @(posedge clock);
      #1;
      check("rst_result", data_result, 0);
      check("rst_rdy", data_resultRDY, 0);
      check("rst_busy", busy, 0);
      check("rst_req", alu_req, 0);
      check("rst_opa", alu_operandA, 0);
      check("rst_opb", alu_operandB, 0);
      check("opcode", alu_opcode, 0);
      check("shamt", alu_shiftamt, 0);
      ctrl_reset = 1'b0;
      @(posedge clock);
      #1;

      // 1: 3*5, N=3
      clear_stim();
      start(32'd3, 32'd5);
      watch(6);
      check("t1_rdy", rdy_m[6:1], 6'b001000);
      check("t1_res", res_m[4], 32'd15);
      check("t1_busy", busy_m[6:1], 6'b001111);
      check("t1_req", req_m[6:1], 6'b000111);
      check("t1_hold", res_m[6], 32'd15);

      // 2: 7*0, N=1
      clear_stim();
      start(32'd7, 32'd0);
      watch(3);
      check("t2_rdy", rdy_m[3:1], 3'b010);
      check("t2_res", res_m[2], 32'd0);
      check("t2_opb", ab_m[1], 32'd0);

      // 3a: (-3)*(-4), N=32
      clear_stim();
      start(32'hFFFFFFFD, 32'hFFFFFFFC);
      watch(34);
      check("t3_rdy", rdy_m[34:1], 34'h1_0000_0000);
      check("t3_res", res_m[33], 32'h0000000C);

      // 3b: wraparound, N=2
      clear_stim();
      start(32'h80000000, 32'd2);
      watch(4);
      check("t3b_rdy", rdy_m[4:1], 4'b0100);
      check("t3b_res", res_m[3], 32'd0);

      // 4: 3*5 with stalls in cycles 2 and 3
      clear_stim();
      stall_m[2] = 1'b1;
      stall_m[3] = 1'b1;
      start(32'd3, 32'd5);
      watch(7);
      check("t4_rdy", rdy_m[7:1], 7'b0100000);
      check("t4_res", res_m[6], 32'd15);
      check("t4_req", req_m[7:1], 7'b0011111);
      check("t4_opb1", ab_m[1], 32'd3);
      check("t4_acc3", aa_m[3], 32'd3);
      check("t4_acc4", aa_m[4], 32'd3);
      check("t4_opb5", ab_m[5], 32'd12);
      check("t4_acc5", aa_m[5], 32'd3);

      // 5: abort (-1)*(-1) by reset in cycle 10
      clear_stim();
      rst_m[10] = 1'b1;
      start(32'hFFFFFFFF, 32'hFFFFFFFF);
      watch(14);
      check("t5_pre", res_m[10], 32'd15);
      check("t5_rdy", rdy_m[14:1], 14'd0);
      check("t5_res", res_m[11], 32'd0);
      check("t5_busy", busy_m[11], 1'b0);
      check("t5_req", req_m[11], 1'b0);
      check("t5_opa", aa_m[11], 32'd0);
      check("t5_opb", ab_m[11], 32'd0);
      clear_stim();
      start(32'd2, 32'd2);
      watch(4);
      check("t5b_rdy", rdy_m[4:1], 4'b0100);
      check("t5b_res", res_m[3], 32'd4);

      // 6: ignored start in RUN, chained start in DONE
      clear_stim();
      mult_m[2] = 1'b1;
      opa_in[2] = 32'd9;
      opb_in[2] = 32'd9;
      mult_m[4] = 1'b1;
      opa_in[4] = 32'd6;
      opb_in[4] = 32'd7;
      start(32'd3, 32'd5);
      watch(10);
      check("t6_rdy", rdy_m[10:1], 10'b0010001000);
      check("t6_res1", res_m[4], 32'd15);
      check("t6_res2", res_m[8], 32'd42);
      check("t6_busy", busy_m[10:1], 10'b0011111111);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
